// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Hardwired Moore sequencer: fetch, decode ir[31:27], one strobe
//            step per clock, with run/halt handling and memory wait states.
// Revision : 1.0  initial release
// ============================================================================
module control_unit #(
   parameter logic [4:0] ALU_INC = 5'd12,
   parameter logic [4:0] ALU_ADD = 5'd3,
   parameter logic [4:0] ALU_AND = 5'd10,
   parameter logic [4:0] ALU_OR  = 5'd11
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] ir,
   input  logic        con_ff,
   input  logic        mem_ready,
   input  logic        stop,
   output logic        run,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        Read,
   output logic        Write,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        BAout,
   output logic        Cout,
   output logic        CONin,
   output logic        OutportIn,
   output logic        InPortOut,
   output logic [4:0]  OpCode
);

   localparam logic [3:0] S_RESET = 4'd0;
   localparam logic [3:0] S_T0    = 4'd1;
   localparam logic [3:0] S_T1    = 4'd2;
   localparam logic [3:0] S_T2    = 4'd3;
   localparam logic [3:0] S_T3    = 4'd4;
   localparam logic [3:0] S_T4    = 4'd5;
   localparam logic [3:0] S_T5    = 4'd6;
   localparam logic [3:0] S_T6    = 4'd7;
   localparam logic [3:0] S_T7    = 4'd8;
   localparam logic [3:0] S_T8    = 4'd9;
   localparam logic [3:0] S_HALT  = 4'd10;

   localparam logic [4:0] OP_LD   = 5'd0;
   localparam logic [4:0] OP_LDI  = 5'd1;
   localparam logic [4:0] OP_ST   = 5'd2;
   localparam logic [4:0] OP_ADDI = 5'd12;
   localparam logic [4:0] OP_ANDI = 5'd13;
   localparam logic [4:0] OP_ORI  = 5'd14;
   localparam logic [4:0] OP_BR   = 5'd18;
   localparam logic [4:0] OP_JR   = 5'd19;
   localparam logic [4:0] OP_IN   = 5'd22;
   localparam logic [4:0] OP_OUT  = 5'd23;
   localparam logic [4:0] OP_HALT = 5'd27;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [3:0] w_boundary;
   logic [4:0] w_op;
   logic       w_unused_ir;
   logic       w_is_ld, w_is_ldi, w_is_st, w_is_alu, w_is_imm;
   logic       w_is_br, w_is_jr, w_is_in, w_is_out, w_is_halt;
   logic       w_is_mem, w_is_short, w_has_exec;
   logic [4:0] w_imm_op;

   assign w_op        = ir[31:27];
   assign w_unused_ir = ^ir[26:0];

   assign w_is_ld   = (w_op == OP_LD);
   assign w_is_ldi  = (w_op == OP_LDI);
   assign w_is_st   = (w_op == OP_ST);
   assign w_is_alu  = (w_op >= 5'd3) && (w_op <= 5'd11);
   assign w_is_imm  = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
   assign w_is_br   = (w_op == OP_BR);
   assign w_is_jr   = (w_op == OP_JR);
   assign w_is_in   = (w_op == OP_IN);
   assign w_is_out  = (w_op == OP_OUT);
   assign w_is_halt = (w_op == OP_HALT);

   assign w_is_mem   = w_is_ld || w_is_st;
   assign w_is_short = w_is_jr || w_is_in || w_is_out;
   assign w_has_exec = w_is_mem || w_is_ldi || w_is_alu || w_is_imm ||
                       w_is_br || w_is_short;

   assign w_imm_op = (w_op == OP_ANDI) ? ALU_AND :
                     (w_op == OP_ORI)  ? ALU_OR  : ALU_ADD;

   // stop is only honoured on the edge that ends an instruction
   assign w_boundary = stop ? S_HALT : S_T0;

   always_comb begin
      w_next = S_RESET;
      case (r_state)
         S_RESET: w_next = S_T0;
         S_T0:    w_next = S_T1;
         S_T1:    w_next = S_T2;
         S_T2:    w_next = mem_ready ? S_T3 : S_T2;
         S_T3: begin
            if (w_is_halt)
               w_next = S_HALT;
            else if (w_has_exec)
               w_next = S_T4;
            else
               w_next = w_boundary;
         end
         S_T4:    w_next = w_is_short ? w_boundary : S_T5;
         S_T5:    w_next = S_T6;
         S_T6:    w_next = (w_is_mem || w_is_br) ? S_T7 : w_boundary;
         S_T7: begin
            if (w_is_ld)
               w_next = mem_ready ? S_T8 : S_T7;
            else if (w_is_st)
               w_next = S_T8;
            else
               w_next = w_boundary;
         end
         S_T8: begin
            if (w_is_st && !mem_ready)
               w_next = S_T8;
            else
               w_next = w_boundary;
         end
         S_HALT:  w_next = S_HALT;
         default: w_next = S_RESET;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         r_state <= S_RESET;
      else
         r_state <= w_next;
   end

   assign run = (r_state >= S_T0) && (r_state <= S_T8);

   always_comb begin
      PCout     = 1'b0;
      Zlowout   = 1'b0;
      MDRout    = 1'b0;
      MARin     = 1'b0;
      Zin       = 1'b0;
      PCin      = 1'b0;
      MDRin     = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      Read      = 1'b0;
      Write     = 1'b0;
      Gra       = 1'b0;
      Grb       = 1'b0;
      Grc       = 1'b0;
      Rin       = 1'b0;
      Rout      = 1'b0;
      BAout     = 1'b0;
      Cout      = 1'b0;
      CONin     = 1'b0;
      OutportIn = 1'b0;
      InPortOut = 1'b0;
      OpCode    = 5'd0;
      case (r_state)
         S_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            Zin    = 1'b1;
            OpCode = ALU_INC;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
         end
         S_T2: begin
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         S_T3: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T4: begin
            if (w_is_mem || w_is_ldi) begin
               Grb   = 1'b1;
               BAout = 1'b1;
               Yin   = 1'b1;
            end else if (w_is_alu || w_is_imm) begin
               Grb  = 1'b1;
               Rout = 1'b1;
               Yin  = 1'b1;
            end else if (w_is_br) begin
               Gra   = 1'b1;
               Rout  = 1'b1;
               CONin = 1'b1;
            end else if (w_is_jr) begin
               Gra  = 1'b1;
               Rout = 1'b1;
               PCin = 1'b1;
            end else if (w_is_in) begin
               Gra       = 1'b1;
               Rin       = 1'b1;
               InPortOut = 1'b1;
            end else if (w_is_out) begin
               Gra       = 1'b1;
               Rout      = 1'b1;
               OutportIn = 1'b1;
            end
         end
         S_T5: begin
            if (w_is_mem || w_is_ldi) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               OpCode = ALU_ADD;
            end else if (w_is_alu) begin
               Grc    = 1'b1;
               Rout   = 1'b1;
               Zin    = 1'b1;
               OpCode = w_op;
            end else if (w_is_imm) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               OpCode = w_imm_op;
            end else if (w_is_br) begin
               PCout = 1'b1;
               Yin   = 1'b1;
            end
         end
         S_T6: begin
            if (w_is_mem) begin
               Zlowout = 1'b1;
               MARin   = 1'b1;
            end else if (w_is_ldi || w_is_alu || w_is_imm) begin
               Zlowout = 1'b1;
               Gra     = 1'b1;
               Rin     = 1'b1;
            end else if (w_is_br) begin
               Cout   = 1'b1;
               Zin    = 1'b1;
               OpCode = ALU_ADD;
            end
         end
         S_T7: begin
            if (w_is_ld) begin
               Read  = 1'b1;
               MDRin = 1'b1;
            end else if (w_is_st) begin
               Gra   = 1'b1;
               Rout  = 1'b1;
               MDRin = 1'b1;
            end else if (w_is_br && con_ff) begin
               Zlowout = 1'b1;
               PCin    = 1'b1;
            end
         end
         S_T8: begin
            if (w_is_ld) begin
               MDRout = 1'b1;
               Gra    = 1'b1;
               Rin    = 1'b1;
            end else if (w_is_st) begin
               Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Purpose  : Scoreboard bench for control_unit: expected per-cycle strobe
//            vectors are queued with the stimulus and compared each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] ir = 32'd0;
   logic        con_ff = 1'b0;
   logic        mem_ready = 1'b1;
   logic        stop = 1'b0;
   logic        run, PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin;
   logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
   logic        OutportIn, InPortOut;
   logic [4:0]  OpCode;

   int checks = 0;
   int failures = 0;

   control_unit dut (
      .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
      .stop(stop), .run(run), .PCout(PCout), .Zlowout(Zlowout),
      .MDRout(MDRout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .Read(Read), .Write(Write), .Gra(Gra),
      .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .Cout(Cout), .CONin(CONin), .OutportIn(OutportIn),
      .InPortOut(InPortOut), .OpCode(OpCode)
   );

   always #5 clk = ~clk;

   localparam logic [26:0] M_RUN  = 27'd1 << 26;
   localparam logic [26:0] M_PCO  = 27'd1 << 25;
   localparam logic [26:0] M_ZLO  = 27'd1 << 24;
   localparam logic [26:0] M_MDRO = 27'd1 << 23;
   localparam logic [26:0] M_MARI = 27'd1 << 22;
   localparam logic [26:0] M_ZIN  = 27'd1 << 21;
   localparam logic [26:0] M_PCI  = 27'd1 << 20;
   localparam logic [26:0] M_MDRI = 27'd1 << 19;
   localparam logic [26:0] M_IRI  = 27'd1 << 18;
   localparam logic [26:0] M_YIN  = 27'd1 << 17;
   localparam logic [26:0] M_RD   = 27'd1 << 16;
   localparam logic [26:0] M_WR   = 27'd1 << 15;
   localparam logic [26:0] M_GRA  = 27'd1 << 14;
   localparam logic [26:0] M_GRB  = 27'd1 << 13;
   localparam logic [26:0] M_GRC  = 27'd1 << 12;
   localparam logic [26:0] M_RIN  = 27'd1 << 11;
   localparam logic [26:0] M_ROUT = 27'd1 << 10;
   localparam logic [26:0] M_BAO  = 27'd1 << 9;
   localparam logic [26:0] M_COUT = 27'd1 << 8;
   localparam logic [26:0] M_CONI = 27'd1 << 7;
   localparam logic [26:0] M_OPI  = 27'd1 << 6;
   localparam logic [26:0] M_IPO  = 27'd1 << 5;

   localparam logic [26:0] F0 = M_RUN | M_PCO | M_MARI | M_ZIN | 27'd12;
   localparam logic [26:0] F1 = M_RUN | M_ZLO | M_PCI;
   localparam logic [26:0] F2 = M_RUN | M_RD | M_MDRI;
   localparam logic [26:0] F3 = M_RUN | M_MDRO | M_IRI;
   localparam logic [26:0] E_ADR4 = M_RUN | M_GRB | M_BAO | M_YIN;
   localparam logic [26:0] E_ADR5 = M_RUN | M_COUT | M_ZIN | 27'd3;
   localparam logic [26:0] E_RR4  = M_RUN | M_GRB | M_ROUT | M_YIN;
   localparam logic [26:0] E_WB   = M_RUN | M_ZLO | M_GRA | M_RIN;

   typedef struct packed {
      logic [26:0] vec;
      logic [31:0] ir;
      logic        cf;
      logic        mr;
      logic        st;
   } item_t;

   item_t       sb[$];
   logic [31:0] cur_ir = 32'd0;
   logic        cur_cf = 1'b0;

   function automatic logic [26:0] obs();
      return {run, PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
              Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin,
              OutportIn, InPortOut, OpCode};
   endfunction

   task automatic push(input logic [26:0] v, input logic mr, input logic st);
      item_t it;
      it.vec = v; it.ir = cur_ir; it.cf = cur_cf; it.mr = mr; it.st = st;
      sb.push_back(it);
   endtask

   task automatic pv(input logic [26:0] v);
      push(v, 1'b1, 1'b0);
   endtask

   task automatic push_fetch(input logic [31:0] instr);
      cur_ir = instr;
      pv(F0); pv(F1); pv(F2); pv(F3);
   endtask

   // Holds clr over one edge and leaves the DUT in S_RESET at a falling edge.
   task automatic start();
      sb.delete();
      clr = 1'b1; mem_ready = 1'b1; stop = 1'b0;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      pv(27'd0);
   endtask

   task automatic test_reset();
      item_t it;
      int cyc = 0;
      start();
      push_fetch(32'h1A2C0000);
      pv(E_RR4);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL reset_pre cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
      #1;
      checks++;
      if (obs() !== (M_RUN | M_GRC | M_ROUT | M_ZIN | 27'd3)) begin
         failures++;
         $display("FAIL reset_t5 got=%h exp=%h", obs(), M_RUN | M_GRC | M_ROUT | M_ZIN | 27'd3);
      end
      #1 clr = 1'b1;
      #1;
      checks++;
      if (obs() !== 27'd0) begin
         failures++;
         $display("FAIL reset_async got=%h exp=0", obs());
      end
      @(negedge clk);
      clr = 1'b0;
      #1;
      checks++;
      if (obs() !== 27'd0) begin
         failures++;
         $display("FAIL reset_hold got=%h exp=0", obs());
      end
      @(negedge clk);
      #1;
      checks++;
      if (obs() !== F0) begin
         failures++;
         $display("FAIL reset_t0 got=%h exp=%h", obs(), F0);
      end
   endtask

   task automatic test_short_ops();
      item_t it;
      int cyc = 0;
      start();
      push_fetch(32'hB1800000); pv(M_RUN | M_GRA | M_RIN | M_IPO);
      push_fetch(32'hB8000000); pv(M_RUN | M_GRA | M_ROUT | M_OPI);
      push_fetch(32'h98000000); pv(M_RUN | M_GRA | M_ROUT | M_PCI);
      pv(F0);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL short_ops cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_alu();
      item_t it;
      int cyc = 0;
      start();
      push_fetch(32'h1A2C0000); pv(E_RR4);
      pv(M_RUN | M_GRC | M_ROUT | M_ZIN | 27'd3); pv(E_WB);
      push_fetch(32'h58000000); pv(E_RR4);
      pv(M_RUN | M_GRC | M_ROUT | M_ZIN | 27'd11); pv(E_WB);
      push_fetch(32'h60000000); pv(E_RR4); pv(M_RUN | M_COUT | M_ZIN | 27'd3); pv(E_WB);
      push_fetch(32'h68000000); pv(E_RR4); pv(M_RUN | M_COUT | M_ZIN | 27'd10); pv(E_WB);
      push_fetch(32'h70000000); pv(E_RR4); pv(M_RUN | M_COUT | M_ZIN | 27'd11); pv(E_WB);
      push_fetch(32'h08800000); pv(E_ADR4); pv(E_ADR5); pv(E_WB);
      pv(F0);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL alu cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_mem_wait();
      item_t it;
      int cyc = 0;
      start();
      push_fetch(32'h00800000); pv(E_ADR4); pv(E_ADR5);
      push(M_RUN | M_ZLO | M_MARI, 1'b0, 1'b0);
      push(M_RUN | M_RD | M_MDRI, 1'b0, 1'b0);
      push(M_RUN | M_RD | M_MDRI, 1'b0, 1'b0);
      push(M_RUN | M_RD | M_MDRI, 1'b0, 1'b0);
      pv(M_RUN | M_RD | M_MDRI);
      pv(M_RUN | M_MDRO | M_GRA | M_RIN);
      cur_ir = 32'h10800000;
      pv(F0); push(F1, 1'b0, 1'b0); push(F2, 1'b0, 1'b0); pv(F2); pv(F3);
      pv(E_ADR4); pv(E_ADR5); pv(M_RUN | M_ZLO | M_MARI);
      push(M_RUN | M_GRA | M_ROUT | M_MDRI, 1'b0, 1'b0);
      push(M_RUN | M_WR, 1'b0, 1'b0);
      push(M_RUN | M_WR, 1'b0, 1'b0);
      pv(M_RUN | M_WR);
      pv(F0);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL mem_wait cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      item_t it;
      int cyc = 0;
      start();
      for (int c = 0; c < 2; c++) begin
         cur_cf = c[0];
         push_fetch(32'h90000000);
         pv(M_RUN | M_GRA | M_ROUT | M_CONI);
         pv(M_RUN | M_PCO | M_YIN);
         pv(M_RUN | M_COUT | M_ZIN | 27'd3);
         pv(c[0] ? (M_RUN | M_ZLO | M_PCI) : M_RUN);
      end
      pv(F0);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL branch cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
      cur_cf = 1'b0;
   endtask

   task automatic test_halt();
      item_t it;
      int cyc = 0;
      start();
      push_fetch(32'hD8000000);
      for (int k = 0; k < 20; k++) push(27'd0, 1'b0, 1'b0);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL halt_op cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
      start();
      push_fetch(32'h1A2C0000);
      push(E_RR4, 1'b1, 1'b1);
      push(M_RUN | M_GRC | M_ROUT | M_ZIN | 27'd3, 1'b1, 1'b1);
      push(E_WB, 1'b1, 1'b1);
      for (int k = 0; k < 20; k++) push(27'd0, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL halt_stop cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      item_t it;
      int cyc = 0;
      start();
      push_fetch(32'hD0000000);
      push_fetch(32'hF0000000);
      push_fetch(32'h78000000);
      cur_ir = 32'hD0000000;
      pv(F0); pv(F1); pv(F2); push(F3, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) pv(27'd0);
      while (sb.size() > 0) begin
         it = sb.pop_front(); ir = it.ir; con_ff = it.cf;
         #1;
         checks++;
         if (obs() !== it.vec) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d got=%h exp=%h", cyc, obs(), it.vec);
         end
         mem_ready = it.mr; stop = it.st; cyc++;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_short_ops();
      test_alu();
      test_mem_wait();
      test_branch();
      test_halt();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
